multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM that drives the multicycle ARM datapath: a shared memory port, instruction register, single ALU and result mux stepped across several cycles per instruction. Decodes Op/Funct/Rd from the instruction register, holds the NZCV flag register, evaluates the condition field once per instruction and emits per-cycle datapath enables and mux selects. Sits between the instruction register and the datapath in the multicycle processor top.

## Interface
- `NZCV_RESET`, default 4'b0000: flag register value after reset.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-low.
- `Cond`  in  4  Instr[31:28].
- `Op`  in  2  Instr[27:26].
- `Funct`  in  6  Instr[25:20].
- `Rd`  in  4  Instr[15:12].
- `ALUFlags`  in  4  {N,Z,C,V} from ALU, current cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  datapath write enables.
- `AdrSrc`  out  1  0=PC, 1=ALUOut to memory address.
- `ALUSrcA`  out  1  0=RD1, 1=PC.
- `ALUSrcB`  out  2  00=RD2, 01=ExtImm, 10=const 4.
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALU result.
- `ALUControl`  out  2  00 add, 01 sub, 10 and, 11 orr.
- `ImmSrc`, `RegSrc`  out  2 each  extender / register-address selects.
- `state_o`  out  4  current state encoding (debug).

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9; others decode to FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 (unconditional) -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10. Next: Op=01 -> MEMADR; Op=00, Funct[5]=0 -> EXECUTER; Op=00, Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (no writes).
- MEMADR: ALUSrcA=0, ALUSrcB=01, add; Funct[0]=1 -> MEMRD else MEMWR.
- MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW -> FETCH. MEMWR: AdrSrc=1, MemW -> FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU-decode; EXECUTEI: ALUSrcB=01, else same; both -> ALUWB. ALUWB: ResultSrc=00, RegW -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, Branch -> FETCH.
- ALU decode (execute states only; add elsewhere), Funct[4:1]: 0100 ADD 00, 0010 SUB 01, 0000 AND 10, 1100 ORR 11, 1010 CMP 01 + NoWrite; other -> 00, RegW suppressed.
- FlagW[1] (N,Z) = Funct[0]; FlagW[0] (C,V) = Funct[0] & ALUControl in {00,01}; only in execute states.
- Condition: EQ..LE standard ARM on registered flags; 1110 always; 1111 never. `cond_ex_q` captured at end of DECODE, used for the rest of the instruction.
- Gating: RegWrite = RegW & cond_ex_q & ~NoWrite; MemWrite = MemW & cond_ex_q; PCWrite also asserted in BRANCH, and in ALUWB/MEMWB when Rd=15 (same gating as RegWrite).
- Flags: each FlagW half loads ALUFlags at end of execute cycle when cond_ex_q=1.
- ImmSrc = Op; RegSrc[0] = (Op=10); RegSrc[1] = (Op=01).

## Timing
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
- All outputs combinational from state and inputs (Moore plus decode); state, flags, cond_ex_q registered.
- reset low at rising edge: state<=FETCH, flags<=NZCV_RESET, cond_ex_q<=0. While reset low, PCWrite/IRWrite/RegWrite/MemWrite forced 0; other outputs show FETCH values.
- Reset mid-instruction aborts; no partial write issued after the reset edge.
- Flags set by instruction N visible to condition check of N+1 (DECODE follows flag update).

## Structure
- Package `multicycle_pkg`: `state_t` enum, cond-code constants, ALUControl / ALUSrcB / ResultSrc encodings.
- Sub-module `cond_check`: combinational Cond x flags -> CondEx, also usable by other cores.

## Test plan
- Reset low 2 cycles, release -> state_o=0, IRWrite=1, PCWrite=1, flags=NZCV_RESET; while low, all write enables 0.
- LDR (Op=01, Funct[0]=1, Cond=1110) -> states 0,1,2,3,4; RegWrite=1 only in state 4, ResultSrc=01.
- SUBS (Funct=000101), ALUFlags=0100 -> flags=0100 after EXECUTER; then BEQ (Cond=0000) -> PCWrite=1 in BRANCH; BNE -> PCWrite=0.
- CMP (Funct=010101) -> flags updated, RegWrite=0 in ALUWB.
- STR with Cond=0000, Z=0 -> MEMWR visited, MemWrite=0; Op=11 -> FETCH after DECODE, no writes.
- reset low in MEMRD of LDR -> next state FETCH, no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Imported by the controller top and the condition checker.
package multicycle_pkg;

    // Controller sequencing states; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ARM condition field values.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ALUControl encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALUSrcB encodings.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc encodings.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Op field classes.
    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    // Data-processing cmd field (Funct[4:1]) values.
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Maps a cmd field to {no_write, alu_control}; unknown cmds add and
    // never write the register file.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        logic [2:0] r;
        r = {1'b1, ALU_ADD};
        case (cmd)
            CMD_ADD: r = {1'b0, ALU_ADD};
            CMD_SUB: r = {1'b0, ALU_SUB};
            CMD_AND: r = {1'b0, ALU_AND};
            CMD_ORR: r = {1'b0, ALU_ORR};
            CMD_CMP: r = {1'b1, ALU_SUB};
            default: r = {1'b1, ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition evaluator: condition field against NZCV flags.
// Purely combinational so other cores can reuse it.
module cond_check
    import multicycle_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign {n, z, c, v} = flags;

    // Standard ARM condition table; 1111 never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle ARM datapath.
// Decodes the instruction register, holds NZCV and gates writes by condition.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter logic [3:0] NZCV_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] state_o
);

    state_t     state_q;
    state_t     state_d;
    state_t     state_cur;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_q;
    logic       cond_ex_d;
    logic       cond_ex;

    logic       pc_update;
    logic       ir_write;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       exec;
    logic       in_aluwb;
    logic [2:0] dec;
    logic       dec_no_write;
    logic [1:0] dec_alu;
    logic [1:0] flag_w;
    logic       rf_write;
    logic       wr_en;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // While reset is held the outputs behave as in FETCH.
    always_comb begin
        state_cur = reset ? state_q : S_FETCH;
        wr_en     = reset;
        state_o   = state_cur;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d   = S_FETCH;
        pc_update = 1'b0;
        ir_write  = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        exec      = 1'b0;
        in_aluwb  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state_cur)
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECUTER: begin
                exec    = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                exec    = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w    = 1'b1;
                in_aluwb = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                ir_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                pc_update = 1'b1;
                state_d   = S_DECODE;
            end
        endcase
    end

    // ALU decode, flag-write enables and register-address selects.
    always_comb begin
        dec          = alu_decode(Funct[4:1]);
        dec_no_write = dec[2];
        dec_alu      = dec[1:0];
        ALUControl   = exec ? dec_alu : ALU_ADD;
        flag_w[1]    = exec & Funct[0];
        flag_w[0]    = exec & Funct[0] & ~dec_alu[1];
        ImmSrc       = Op;
        RegSrc[0]    = (Op == OP_BR);
        RegSrc[1]    = (Op == OP_MEM);
    end

    // Condition-gated write enables; a write to R15 also loads the PC.
    always_comb begin
        rf_write = reg_w & cond_ex_q & ~(in_aluwb & dec_no_write);
        RegWrite = wr_en & rf_write;
        MemWrite = wr_en & mem_w & cond_ex_q;
        IRWrite  = wr_en & ir_write;
        PCWrite  = wr_en & (pc_update
                            | (branch & cond_ex_q)
                            | (rf_write & (Rd == 4'd15)));
    end

    // Flag update at the end of a passing execute cycle; condition latch in DECODE.
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (flag_w[1] && cond_ex_q) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (flag_w[0] && cond_ex_q) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
        if (state_cur == S_DECODE) begin
            cond_ex_d = cond_ex;
        end
    end

    // State, flag and condition registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            flags_q   <= NZCV_RESET;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-level model.
// Directed sequences pin the model with hand-computed values.
module tb_multicycle_controller;

    localparam logic [3:0] NZCV_RESET = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_controller #(.NZCV_RESET(NZCV_RESET)) dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .state_o    (state_o)
    );

    // [19]PCW [18]IRW [17]RegW [16]MemW [15]Adr [14]SrcA [13:12]SrcB
    // [11:10]Res [9:8]ALU [7:6]Imm [5:4]RegSrc [3:0]state
    logic [19:0] dut_vec;
    assign dut_vec = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, state_o};

    int          n_vec = 0;
    int          n_err = 0;
    int          m_step = 0;
    logic [3:0]  m_flags = NZCV_RESET;
    logic        m_cex = 1'b0;
    logic [19:0] exp_vec_q;
    bit          chk_en = 0;
    logic [19:0] obs [0:7];
    int          obs_n;

    function automatic int seq_len(logic [1:0] op, logic [5:0] fn);
        case (op)
            2'b01:   return fn[0] ? 5 : 4;
            2'b00:   return 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Visited state numbers, step by step, for each instruction class.
    function automatic logic [3:0] seq_state(logic [1:0] op, logic [5:0] fn, int step);
        if (step == 0) return 4'd0;
        if (step == 1) return 4'd1;
        case (op)
            2'b01: begin
                if (step == 2) return 4'd2;
                if (step == 3) return fn[0] ? 4'd3 : 4'd5;
                return 4'd4;
            end
            2'b00:   return (step == 2) ? (fn[5] ? 4'd7 : 4'd6) : 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic cond_eval(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {writes_allowed, alu_control} for a data-processing cmd.
    function automatic logic [2:0] alu_of(logic [3:0] cmd);
        if (cmd == 4'b0100) return 3'b1_00;
        if (cmd == 4'b0010) return 3'b1_01;
        if (cmd == 4'b0000) return 3'b1_10;
        if (cmd == 4'b1100) return 3'b1_11;
        if (cmd == 4'b1010) return 3'b0_01;
        return 3'b0_00;
    endfunction

    function automatic logic [19:0] exp_fn(logic [3:0] st, logic [1:0] op,
                                           logic [5:0] fn, logic [3:0] rd,
                                           logic cex, logic rst);
        logic pcw, irw, rw, mw, adr, sa;
        logic [1:0] sb, res, alu;
        logic [2:0] a;
        logic [3:0] s;
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; sa = 0;
        sb = 2'b00; res = 2'b00; alu = 2'b00;
        a = alu_of(fn[4:1]);
        s = rst ? st : 4'd0;
        case (s)
            4'd0: begin irw = 1; sa = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
            4'd1: begin sa = 1; sb = 2'b10; res = 2'b10; end
            4'd2: sb = 2'b01;
            4'd3: adr = 1;
            4'd4: begin res = 2'b01; rw = cex; pcw = cex && rd == 15; end
            4'd5: begin adr = 1; mw = cex; end
            4'd6: alu = a[1:0];
            4'd7: begin sb = 2'b01; alu = a[1:0]; end
            4'd8: begin rw = cex && a[2]; pcw = rw && rd == 15; end
            default: begin sb = 2'b01; res = 2'b10; pcw = cex; end
        endcase
        if (!rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {pcw, irw, rw, mw, adr, sa, sb, res, alu, op,
                op == 2'b01, op == 2'b10, s};
    endfunction

    task automatic model_update(logic rst);
        logic [3:0] st;
        logic [2:0] a;
        if (!rst) begin
            m_step = 0; m_flags = NZCV_RESET; m_cex = 0;
            return;
        end
        st = seq_state(Op, Funct, m_step);
        a = alu_of(Funct[4:1]);
        if (st == 4'd1) m_cex = cond_eval(Cond, m_flags);
        if ((st == 4'd6 || st == 4'd7) && m_cex && Funct[0]) begin
            m_flags[3:2] = ALUFlags[3:2];
            if (a[1:0] == 2'b00 || a[1:0] == 2'b01) m_flags[1:0] = ALUFlags[1:0];
        end
        m_step++;
        if (m_step == seq_len(Op, Funct)) m_step = 0;
    endtask

    // Every cycle: DUT outputs against the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (dut_vec !== exp_vec_q) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t got %h want %h",
                         $time, dut_vec, exp_vec_q);
            end
        end
    end

    task automatic check(string name, logic [19:0] got, logic [19:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic apply(logic rst, logic [3:0] af);
        reset = rst;
        ALUFlags = af;
        exp_vec_q = exp_fn(seq_state(Op, Funct, m_step), Op, Funct, Rd, m_cex, rst);
        chk_en = 1;
        @(negedge clk);
        if (obs_n < 8) obs[obs_n] = dut_vec;
        obs_n++;
        @(posedge clk);
        model_update(rst);
        #1;
    endtask

    task automatic run_instr(logic [3:0] c, logic [1:0] op, logic [5:0] fn,
                             logic [3:0] rd, logic [3:0] af, bit rnd_af, int abort_at);
        int len;
        Cond = c; Op = op; Funct = fn; Rd = rd;
        obs_n = 0;
        len = seq_len(op, fn);
        for (int s = 0; s < len; s++) begin
            if (s == abort_at) begin
                apply(1'b0, rnd_af ? 4'($urandom) : af);
                return;
            end
            apply(1'b1, rnd_af ? 4'($urandom) : af);
        end
    endtask

    initial begin
        int ab;
        logic [3:0] rc;
        reset = 0; Cond = 4'he; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        obs_n = 0;
        apply(1'b0, 4'd0);
        apply(1'b0, 4'd0);
        check("reset_enables_low", {obs[0][19:16], obs[1][19:16]}, 20'h00);
        check("reset_state", {obs[0][3:0], obs[1][3:0]}, 20'h00);

        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'h0, 0, -1);
        check("release_fetch", obs[0][19:18], 20'h3);
        check("release_state", obs[0][3:0], 20'h0);
        check("beq_reset_flags", obs[2][19], 20'h0);
        run_instr(4'h1, 2'b10, 6'd0, 4'd0, 4'h0, 0, -1);
        check("bne_reset_flags", obs[2][19], 20'h1);

        run_instr(4'he, 2'b01, 6'b011001, 4'd3, 4'h0, 0, -1);
        check("ldr_states", {obs[0][3:0], obs[1][3:0], obs[2][3:0],
                             obs[3][3:0], obs[4][3:0]}, 20'h01234);
        check("ldr_regwrite", {obs[0][17], obs[1][17], obs[2][17],
                               obs[3][17], obs[4][17]}, 20'b00001);
        check("ldr_resultsrc", obs[4][11:10], 20'h1);

        run_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0100, 0, -1);
        check("subs_states", {obs[2][3:0], obs[3][3:0]}, 20'h68);
        check("subs_alu", obs[2][9:8], 20'h1);
        check("subs_regwrite", obs[3][17], 20'h1);
        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'h0, 0, -1);
        check("beq_taken", obs[2][19], 20'h1);
        run_instr(4'h1, 2'b10, 6'd0, 4'd0, 4'h0, 0, -1);
        check("bne_not_taken", obs[2][19], 20'h0);

        run_instr(4'he, 2'b00, 6'b010101, 4'd2, 4'b1000, 0, -1);
        check("cmp_no_regwrite", obs[3][17], 20'h0);
        check("cmp_alu_sub", obs[2][9:8], 20'h1);
        run_instr(4'h4, 2'b10, 6'd0, 4'd0, 4'h0, 0, -1);
        check("bmi_taken", obs[2][19], 20'h1);

        run_instr(4'h0, 2'b01, 6'b011000, 4'd1, 4'h0, 0, -1);
        check("str_eq_state", obs[3][3:0], 20'h5);
        check("str_eq_no_memwrite", obs[3][16], 20'h0);
        run_instr(4'he, 2'b01, 6'b011000, 4'd1, 4'h0, 0, -1);
        check("str_al_memwrite", obs[3][16], 20'h1);

        run_instr(4'he, 2'b11, 6'd0, 4'd0, 4'h0, 0, -1);
        check("op11_len", obs_n, 20'd2);
        check("op11_no_writes", {obs[1][19:16], obs[1][3:0]}, 20'h01);

        run_instr(4'he, 2'b00, 6'b001000, 4'd15, 4'h0, 0, -1);
        check("add_r15_pcwrite", {obs[3][19], obs[3][17]}, 20'h3);

        run_instr(4'he, 2'b01, 6'b011001, 4'd3, 4'h0, 0, 3);
        check("abort_no_regwrite", {obs[3][17], obs[3][3:0]}, 20'h00);
        run_instr(4'he, 2'b11, 6'd0, 4'd0, 4'h0, 0, -1);
        check("after_abort_fetch", {obs[0][18], obs[0][3:0]}, 20'h10);

        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(rc, 2'($urandom), 6'($urandom), 4'($urandom),
                      4'h0, 1, ab);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
